// File: rtl/vm_pkg.sv
// Shared definitions for the multi-product vending controller: state encoding,
// coin values in half-lira units and price-table field extraction.
package vm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vm_state_e;

    localparam int HALF_UNIT = 1;
    localparam int ONE_UNIT  = 2;

    // Returns field idx of a packed table of w-bit prices (w <= 16).
    function automatic logic [15:0] price_field(input logic [127:0] prices,
                                                input int idx,
                                                input int w);
        logic [15:0] mask;
        mask = 16'((32'd1 << w) - 32'd1);
        return 16'(prices >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/vm_change_dispenser.sv
// Change counter: pays out one coin per step, 1 TL first, then 0.5 TL.
// Pulses are registered; load and step may coincide so the first coin leaves on the load edge.
module vm_change_dispenser #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         step_i,
    output logic         change1_o,
    output logic         change05_o,
    output logic [W-1:0] remain_o,
    output logic         done_o
);
    import vm_pkg::*;

    localparam logic [W-1:0] ONE_W  = W'(ONE_UNIT);
    localparam logic [W-1:0] HALF_W = W'(HALF_UNIT);

    logic [W-1:0] remain_q, remain_d, src;
    logic         change1_q, change1_d;
    logic         change05_q, change05_d;

    always_comb begin
        src        = load_i ? load_val_i : remain_q;
        remain_d   = src;
        change1_d  = 1'b0;
        change05_d = 1'b0;
        if (step_i) begin
            if (src >= ONE_W) begin
                change1_d = 1'b1;
                remain_d  = src - ONE_W;
            end else if (src == HALF_W) begin
                change05_d = 1'b1;
                remain_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            remain_q   <= '0;
            change1_q  <= 1'b0;
            change05_q <= 1'b0;
        end else begin
            remain_q   <= remain_d;
            change1_q  <= change1_d;
            change05_q <= change05_d;
        end
    end

    assign change1_o  = change1_q;
    assign change05_o = change05_q;
    assign remain_o   = remain_q;
    assign done_o     = (remain_q == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// Vending controller for NUM_PROD products priced in half-lira units; all outputs
// registered, so the reaction to inputs sampled at an edge is visible right after it.
module vending_machine_multi
    import vm_pkg::*;
#(
    parameter int                            NUM_PROD   = 4,
    parameter int                            PRICE_W    = 4,
    parameter int                            MAX_CREDIT = 6,
    parameter logic [NUM_PROD*PRICE_W-1:0]   PRICES     = {4'd5, 4'd3, 4'd2, 4'd1}
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Req,
    input  logic                OneTL,
    input  logic                HalfTL,
    input  logic [NUM_PROD-1:0] Sel,
    input  logic                Cancel,
    output logic [NUM_PROD-1:0] Give,
    output logic                Change1,
    output logic                Change05,
    output logic                Reject,
    output logic [PRICE_W-1:0]  Credit,
    output logic                Busy
);

    localparam logic [PRICE_W:0] MAX_W = (PRICE_W + 1)'(MAX_CREDIT);

    vm_state_e             state_q, state_d;
    logic [PRICE_W-1:0]    credit_q, credit_d;
    logic [NUM_PROD-1:0]   give_q, give_d;
    logic                  reject_q, reject_d;
    logic                  busy_q, busy_d;

    logic                  coin;
    logic [PRICE_W:0]      add, sum;
    logic                  sel_any, sel_onehot;
    logic [PRICE_W-1:0]    sel_price;

    logic                  ld, step, rem_zero;
    logic [PRICE_W-1:0]    ld_val, remain;

    always_comb begin
        coin       = OneTL | HalfTL;
        add        = (PRICE_W + 1)'((OneTL ? ONE_UNIT : 0) + (HalfTL ? HALF_UNIT : 0));
        sum        = {1'b0, credit_q} + add;
        sel_any    = (Sel != '0);
        sel_onehot = sel_any && ((Sel & (Sel - NUM_PROD'(1))) == '0);
        sel_price  = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (Sel[i]) begin
                sel_price = PRICE_W'(price_field(128'(PRICES), i, PRICE_W));
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        give_d   = '0;
        reject_d = 1'b0;
        ld       = 1'b0;
        ld_val   = '0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req) begin
                    state_d  = COLLECT;
                    credit_d = '0;
                end else if (coin || sel_any || Cancel) begin
                    reject_d = 1'b1;
                end
            end
            COLLECT: begin
                // Cancel (or a fresh Req with money inserted) outranks coins and Sel.
                if (Cancel || (Req && credit_q != '0)) begin
                    credit_d = '0;
                    if (credit_q != '0) begin
                        state_d = CHANGE;
                        ld      = 1'b1;
                        ld_val  = credit_q;
                        step    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (coin) begin
                    if (sum > MAX_W) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum[PRICE_W-1:0];
                    end
                end else if (sel_any) begin
                    if (!sel_onehot || credit_q < sel_price) begin
                        reject_d = 1'b1;
                    end else begin
                        state_d  = VEND;
                        give_d   = Sel;
                        ld       = 1'b1;
                        ld_val   = credit_q - sel_price;
                        credit_d = '0;
                    end
                end
            end
            VEND: begin
                reject_d = coin;
                if (rem_zero) begin
                    state_d = IDLE;
                end else begin
                    state_d = CHANGE;
                    step    = 1'b1;
                end
            end
            CHANGE: begin
                reject_d = coin;
                if (rem_zero) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
            give_q   <= '0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            give_q   <= give_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
        end
    end

    vm_change_dispenser #(
        .W (PRICE_W)
    ) u_change (
        .clk_i      (Clk),
        .rst_ni     (Rst_n),
        .load_i     (ld),
        .load_val_i (ld_val),
        .step_i     (step),
        .change1_o  (Change1),
        .change05_o (Change05),
        .remain_o   (remain),
        .done_o     (rem_zero)
    );

    // While vending or paying out, the outstanding amount lives in the dispenser.
    assign Credit = busy_q ? remain : credit_q;
    assign Give   = give_q;
    assign Reject = reject_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi: each step drives inputs, queues the
// hand-derived outputs expected after the next edge, and checks them #1 later.
module tb_vending_machine_multi;

    logic       Clk = 1'b0;
    logic       Rst_n, Req, OneTL, HalfTL, Cancel;
    logic [3:0] Sel;
    logic [3:0] Give, Credit;
    logic       Change1, Change05, Reject, Busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] give;
        logic       c1;
        logic       c05;
        logic       rej;
        logic [3:0] cred;
        logic       busy;
    } exp_t;

    exp_t       sb_q[$];
    string      tag_q[$];

    always #5 Clk = ~Clk;

    vending_machine_multi dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Req      (Req),
        .OneTL    (OneTL),
        .HalfTL   (HalfTL),
        .Sel      (Sel),
        .Cancel   (Cancel),
        .Give     (Give),
        .Change1  (Change1),
        .Change05 (Change05),
        .Reject   (Reject),
        .Credit   (Credit),
        .Busy     (Busy)
    );

    task automatic chk(input string tag, input string fld, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp_v);
        end
    endtask

    // Inputs: rst_n req one half sel cancel | expected: give c1 c05 rej cred busy
    task automatic step(input string tag,
                        input logic r_n, input logic rq, input logic one, input logic half,
                        input logic [3:0] s, input logic cn,
                        input logic [3:0] e_give, input logic e_c1, input logic e_c05,
                        input logic e_rej, input logic [3:0] e_cred, input logic e_busy);
        exp_t e;
        exp_t got;
        string t;
        Rst_n = r_n; Req = rq; OneTL = one; HalfTL = half; Sel = s; Cancel = cn;
        e = '{give: e_give, c1: e_c1, c05: e_c05, rej: e_rej, cred: e_cred, busy: e_busy};
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge Clk);
        #1;
        e   = sb_q.pop_front();
        t   = tag_q.pop_front();
        got = '{give: Give, c1: Change1, c05: Change05, rej: Reject, cred: Credit, busy: Busy};
        chk(t, "Give",     int'(got.give), int'(e.give));
        chk(t, "Change1",  int'(got.c1),   int'(e.c1));
        chk(t, "Change05", int'(got.c05),  int'(e.c05));
        chk(t, "Reject",   int'(got.rej),  int'(e.rej));
        chk(t, "Credit",   int'(got.cred), int'(e.cred));
        chk(t, "Busy",     int'(got.busy), int'(e.busy));
        @(negedge Clk);
    endtask

    initial begin
        Rst_n = 1'b0; Req = 1'b0; OneTL = 1'b0; HalfTL = 1'b0; Sel = '0; Cancel = 1'b0;
        @(negedge Clk);
        step("rst0",      0,0,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("rst1",      0,1,1,0,4'b0001,0, 4'b0000,0,0,0,4'd0,0);

        // Exact payment: 0.5 TL for product 0
        step("t1.req",    1,1,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t1.half",   1,0,0,1,4'b0000,0, 4'b0000,0,0,0,4'd1,0);
        step("t1.sel",    1,0,0,0,4'b0001,0, 4'b0001,0,0,0,4'd0,1);
        step("t1.idle",   1,0,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);

        // Product 1 (price 2) with 1 TL, then product 0 with 1.5 TL -> one 1 TL coin back
        step("t2a.req",   1,1,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t2a.one",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd2,0);
        step("t2a.sel",   1,0,0,0,4'b0010,0, 4'b0010,0,0,0,4'd0,1);
        step("t2a.idle",  1,0,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t2b.req",   1,1,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t2b.one",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd2,0);
        step("t2b.half",  1,0,0,1,4'b0000,0, 4'b0000,0,0,0,4'd3,0);
        step("t2b.sel",   1,0,0,0,4'b0001,0, 4'b0001,0,0,0,4'd2,1);
        step("t2b.chg",   1,0,0,0,4'b0000,0, 4'b0000,1,0,0,4'd0,1);
        step("t2b.idle",  1,0,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);

        // Worst-case change from full credit; a coin during payout is refused
        step("t3.req",    1,1,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t3.one1",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd2,0);
        step("t3.one2",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd4,0);
        step("t3.one3",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd6,0);
        step("t3.sel",    1,0,0,0,4'b0001,0, 4'b0001,0,0,0,4'd5,1);
        step("t3.chg1",   1,0,0,0,4'b0000,0, 4'b0000,1,0,0,4'd3,1);
        step("t3.chg2",   1,0,1,0,4'b0000,1, 4'b0000,1,0,1,4'd1,1);
        step("t3.chg3",   1,0,0,0,4'b0000,0, 4'b0000,0,1,0,4'd0,1);
        step("t3.idle",   1,0,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);

        // Credit ceiling, then cancel outranks a coin and a valid Sel
        step("t4.req",    1,1,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t4.one1",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd2,0);
        step("t4.one2",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd4,0);
        step("t4.both",   1,0,1,1,4'b0000,0, 4'b0000,0,0,1,4'd4,0);
        step("t4.one3",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd6,0);
        step("t4.over",   1,0,1,0,4'b0000,0, 4'b0000,0,0,1,4'd6,0);
        step("t4.cancel", 1,0,1,0,4'b0001,1, 4'b0000,1,0,0,4'd4,1);
        step("t4.chg2",   1,0,0,0,4'b0000,0, 4'b0000,1,0,0,4'd2,1);
        step("t4.chg3",   1,0,0,0,4'b0000,0, 4'b0000,1,0,0,4'd0,1);
        step("t4.idle",   1,0,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);

        // Insufficient credit, non-one-hot select, cancel refund
        step("t5.req",    1,1,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t5.half",   1,0,0,1,4'b0000,0, 4'b0000,0,0,0,4'd1,0);
        step("t5.poor",   1,0,0,0,4'b0010,0, 4'b0000,0,0,1,4'd1,0);
        step("t5.multi",  1,0,0,0,4'b0011,0, 4'b0000,0,0,1,4'd1,0);
        step("t5.cancel", 1,0,0,0,4'b0000,1, 4'b0000,0,1,0,4'd0,1);
        step("t5.idle",   1,0,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);

        // Coin with Sel: coin wins silently; Req with credit refunds
        step("t5b.req",   1,1,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t5b.csel",  1,0,0,1,4'b0001,0, 4'b0000,0,0,0,4'd1,0);
        step("t5b.rqref", 1,1,0,0,4'b0000,0, 4'b0000,0,1,0,4'd0,1);
        step("t5b.idle",  1,0,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);

        // Req at zero credit is a no-op; cancel at zero goes straight home
        step("t5c.req",   1,1,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t5c.req2",  1,1,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t5c.cncl",  1,0,0,0,4'b0000,1, 4'b0000,0,0,0,4'd0,0);
        step("t5c.idlec", 1,0,1,0,4'b0000,0, 4'b0000,0,0,1,4'd0,0);

        // Most expensive product (price 5) paid exactly
        step("t7.req",    1,1,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t7.one1",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd2,0);
        step("t7.one2",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd4,0);
        step("t7.half",   1,0,0,1,4'b0000,0, 4'b0000,0,0,0,4'd5,0);
        step("t7.sel",    1,0,0,0,4'b1000,0, 4'b1000,0,0,0,4'd0,1);
        step("t7.idle",   1,0,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);

        // Reset in the middle of payout abandons the remaining change
        step("t6.req",    1,1,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t6.one1",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd2,0);
        step("t6.one2",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd4,0);
        step("t6.one3",   1,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd6,0);
        step("t6.sel",    1,0,0,0,4'b0001,0, 4'b0001,0,0,0,4'd5,1);
        step("t6.chg1",   1,0,0,0,4'b0000,0, 4'b0000,1,0,0,4'd3,1);
        step("t6.rst",    0,0,1,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t6.coin",   1,0,1,0,4'b0000,0, 4'b0000,0,0,1,4'd0,0);
        step("t6.quiet",  1,0,0,0,4'b0000,0, 4'b0000,0,0,0,4'd0,0);
        step("t6.sel",    1,0,0,0,4'b0100,0, 4'b0000,0,0,1,4'd0,0);
        step("t6.cncl",   1,0,0,0,4'b0000,1, 4'b0000,0,0,1,4'd0,0);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard observed=%0d expected=0 pending entries", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
